dut: RTL and testbench

DUT -- requirements
Module: dut

---
 rtl/dut.sv | 59 +++++
 tb/tb_dut.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/dut.sv
// ============================================================================
// dut: loadable up/down counter with zero/max decode and registered wrap pulse.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module dut #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ld_cnt,
  input  logic             updn_cnt,
  input  logic             count_enb,
  output logic [WIDTH-1:0] data_out,
  output logic             cnt_zero,
  output logic             cnt_max,
  output logic             wrap
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;

  // Priority: load, then count, then hold. Only a counting edge can wrap.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (ld_cnt) begin
      cnt_d = data_in;
    end else if (count_enb) begin
      if (updn_cnt) begin
        cnt_d  = cnt_q + WIDTH'(1);
        wrap_d = &cnt_q;
      end else begin
        cnt_d  = cnt_q - WIDTH'(1);
        wrap_d = ~|cnt_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign data_out = cnt_q;
  assign wrap     = wrap_q;
  assign cnt_zero = ~|cnt_q;
  assign cnt_max  = &cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_dut.sv
// ============================================================================
// tb_dut: directed self-checking bench for the dut up/down counter.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dut;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_;
  logic [WIDTH-1:0] data_in;
  logic             ld_cnt;
  logic             updn_cnt;
  logic             count_enb;
  logic [WIDTH-1:0] data_out;
  logic             cnt_zero;
  logic             cnt_max;
  logic             wrap;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dut #(.WIDTH(WIDTH)) u_dut (
    .clk       (clk),
    .rst_      (rst_),
    .data_in   (data_in),
    .ld_cnt    (ld_cnt),
    .updn_cnt  (updn_cnt),
    .count_enb (count_enb),
    .data_out  (data_out),
    .cnt_zero  (cnt_zero),
    .cnt_max   (cnt_max),
    .wrap      (wrap)
  );

  task automatic check_eq(input string tag, input logic [WIDTH-1:0] got,
                          input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply inputs, take one rising edge, settle 1 time unit past it.
  task automatic tick(input logic ld, input logic enb, input logic up,
                      input logic [WIDTH-1:0] din);
    ld_cnt    = ld;
    count_enb = enb;
    updn_cnt  = up;
    data_in   = din;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [WIDTH-1:0] exp_q,
                             input logic exp_wrap);
    check_eq({tag, ".data"}, data_out, exp_q);
    check_eq({tag, ".wrap"}, WIDTH'(wrap), WIDTH'(exp_wrap));
    check_eq({tag, ".zero"}, WIDTH'(cnt_zero), WIDTH'(exp_q == '0));
    check_eq({tag, ".max"},  WIDTH'(cnt_max),  WIDTH'(exp_q == '1));
  endtask

  logic [WIDTH-1:0] exp_up [3]   = '{16'hFFFF, 16'h0000, 16'h0001};
  logic             wrp_up [3]   = '{1'b0, 1'b1, 1'b0};
  logic [WIDTH-1:0] exp_dn [3]   = '{16'h0000, 16'hFFFF, 16'hFFFE};
  logic             wrp_dn [3]   = '{1'b0, 1'b1, 1'b0};
  logic [WIDTH-1:0] exp_ud [8]   = '{16'd1, 16'd2, 16'd3, 16'd4,
                                     16'd3, 16'd2, 16'd1, 16'd0};

  initial begin
    rst_      = 1'b0;
    data_in   = '0;
    ld_cnt    = 1'b0;
    updn_cnt  = 1'b0;
    count_enb = 1'b0;
    #2;
    check_state("reset", 16'h0000, 1'b0);
    @(posedge clk);
    #1;
    rst_ = 1'b1;

    // Up through the all-ones boundary
    tick(1'b1, 1'b0, 1'b0, 16'hFFFE);
    check_state("ld_fffe", 16'hFFFE, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b1, 16'h0000);
      check_state($sformatf("up%0d", i), exp_up[i], wrp_up[i]);
    end

    // Down through zero
    tick(1'b1, 1'b0, 1'b1, 16'h0001);
    check_state("ld_0001", 16'h0001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b0, 16'h0000);
      check_state($sformatf("dn%0d", i), exp_dn[i], wrp_dn[i]);
    end

    // Load beats count
    tick(1'b1, 1'b1, 1'b1, 16'hA5A5);
    check_state("ld_and_cnt", 16'hA5A5, 1'b0);

    // Hold while direction toggles
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, i[0], 16'h0000);
      check_state($sformatf("hold%0d", i), 16'hA5A5, 1'b0);
    end

    // Loading boundary values never wraps
    tick(1'b1, 1'b0, 1'b0, 16'hFFFF);
    check_state("ld_ffff", 16'hFFFF, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 16'h0000);
    check_state("ld_0000", 16'h0000, 1'b0);

    // Up 4, then down 4
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1, (i < 4), 16'h0000);
      check_state($sformatf("updn%0d", i), exp_ud[i], 1'b0);
    end

    // Asynchronous reset between edges, then edges during reset are ignored
    tick(1'b1, 1'b0, 1'b0, 16'h1234);
    check_state("ld_1234", 16'h1234, 1'b0);
    #2;
    rst_ = 1'b0;
    #1;
    check_state("async_rst", 16'h0000, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 16'hBEEF);
    check_state("rst_held_ld", 16'h0000, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 16'h0000);
    check_state("rst_held_cnt", 16'h0000, 1'b0);
    rst_ = 1'b1;
    tick(1'b0, 1'b1, 1'b1, 16'h0000);
    check_state("post_rst_up", 16'h0001, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
